// File: rtl/seq_matcher.sv
// seq_matcher: serial bit-pattern detector with programmable masked slots and a saturating match counter.
module seq_matcher #(
  parameter int          DSIZE   = 8,
  parameter int          NPAT    = 2,
  parameter logic [31:0] PAT_DEF = 32'd85,
  parameter int          CNTW    = 8,
  localparam int         IW      = NPAT > 1 ? $clog2(NPAT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             si,
  input  logic             ovl,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [DSIZE-1:0] cfg_pat,
  input  logic [DSIZE-1:0] cfg_mask,
  input  logic             cnt_clr,
  output logic             match,
  output logic [IW-1:0]    match_id,
  output logic [CNTW-1:0]  match_cnt,
  output logic             cnt_sat
);
  localparam int FW = $clog2(DSIZE + 1);
  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;
  state_t                      state_q, state_d;
  logic [DSIZE-1:0]            shreg_q, shreg_d, shreg_n;
  logic [FW-1:0]               fill_q, fill_d, fill_n;
  logic [NPAT-1:0][DSIZE-1:0]  pat_q, pat_d, mask_q, mask_d;
  logic                        match_q, match_d, hit;
  logic [IW-1:0]               match_id_q, match_id_d, hit_id;
  logic [CNTW-1:0]             cnt_q, cnt_d, cnt_base;
  logic                        sat_q, sat_d;

  always_comb begin
    shreg_n = {shreg_q[DSIZE-2:0], si};
    fill_n  = (state_q == HUNT || fill_q == FW'(DSIZE)) ? FW'(DSIZE) : fill_q + 1'b1;
    hit     = 1'b0;
    hit_id  = '0;
    // descending scan so the lowest hitting slot wins
    for (int k = NPAT - 1; k >= 0; k--)
      if (ena && fill_n == FW'(DSIZE) && ((shreg_n ^ pat_q[k]) & mask_q[k]) == '0) begin
        hit    = 1'b1;
        hit_id = IW'(k);
      end
    shreg_d    = ena ? shreg_n : '0;
    fill_d     = (!ena || (hit && !ovl)) ? '0 : fill_n;
    state_d    = !ena ? IDLE : fill_d == FW'(DSIZE) ? HUNT : FILL;
    match_d    = hit;
    match_id_d = hit ? hit_id : match_id_q;
    // clear first, then count a coincident detection
    cnt_base   = cnt_clr ? '0 : cnt_q;
    cnt_d      = (hit && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
    sat_d      = (!cnt_clr && sat_q) || cnt_d == '1;
    pat_d      = pat_q;
    mask_d     = mask_q;
    for (int k = 0; k < NPAT; k++)
      if (cfg_we && cfg_idx == IW'(k)) begin
        pat_d[k]  = cfg_pat;
        mask_d[k] = cfg_mask;
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      fill_q     <= '0;
      pat_q      <= {NPAT{PAT_DEF[DSIZE-1:0]}};
      mask_q     <= '1;
      match_q    <= 1'b0;
      match_id_q <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      fill_q     <= fill_d;
      pat_q      <= pat_d;
      mask_q     <= mask_d;
      match_q    <= match_d;
      match_id_q <= match_id_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
    end

  assign match     = match_q;
  assign match_id  = match_id_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
endmodule
